// File: rtl/tdm_frame_delay_if.sv
`default_nettype none
// ============================================================================
// Module      : tdm_frame_delay_if
// Description : ST-bus style TDM signal bundle for tdm_frame_delay.
//               master drives c4 / f0 / data_in and observes the engine
//               outputs; slave is the engine side.
//   c4         - asynchronous TDM bit clock
//   f0         - asynchronous frame pulse, active low
//   data_in    - asynchronous serial data, launched on c4
//   data_out   - data_in delayed by DELAY_BITS bits
//   bit_strobe - one-cycle pulse per bit
//   bit_cnt    - current bit index in the frame
//   slot_pulse - high for a whole slot while locked on a masked slot
//   frame_lock - engine is locked to f0
//   err_cnt    - saturating frame-error counter
// Revision    : 1.0 - initial release
// ============================================================================
interface tdm_frame_delay_if;
    logic       c4;
    logic       f0;
    logic       data_in;
    logic       data_out;
    logic       bit_strobe;
    logic [9:0] bit_cnt;
    logic       slot_pulse;
    logic       frame_lock;
    logic [7:0] err_cnt;

    modport master (
        output c4, f0, data_in,
        input  data_out, bit_strobe, bit_cnt, slot_pulse, frame_lock, err_cnt
    );

    modport slave (
        input  c4, f0, data_in,
        output data_out, bit_strobe, bit_cnt, slot_pulse, frame_lock, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/tdm_frame_delay.sv
`default_nettype none
// ============================================================================
// Module      : tdm_frame_delay
// Description : TDM frame engine in the clk50 domain. Synchronises c4/f0/
//               data_in, locks a flywheel bit/slot counter to f0, delays the
//               serial stream by DELAY_BITS bits through a circular buffer
//               and produces slot-marker pulses from SLOT_MASK.
// Ports       : clk50      - system clock, rising edge
//               reset_rg_n - synchronous active-low reset
//               tdm        - tdm_frame_delay_if.slave (c4, f0, data_in in;
//                            data_out, bit_strobe, bit_cnt, slot_pulse,
//                            frame_lock, err_cnt out)
// Options     : TDM_FRAME_DELAY_ERR_CNT_EN - build the frame-error counter;
//               when undefined err_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_frame_delay #(
    parameter int                      FRAME_BITS    = 256,
    parameter int                      TICKS_PER_BIT = 2,
    parameter int                      DELAY_BITS    = 384,
    parameter int                      MISS_LIMIT    = 3,
    parameter logic [FRAME_BITS/8-1:0] SLOT_MASK     = 32'h0000_0015
) (
    input  wire logic        clk50,
    input  wire logic        reset_rg_n,
    tdm_frame_delay_if.slave tdm
);

    localparam int               C_WP_W      = $clog2(DELAY_BITS);
    localparam int               C_FILL_W    = $clog2(DELAY_BITS + 1);
    localparam logic [9:0]       C_LAST_BIT  = 10'(FRAME_BITS - 1);
    localparam logic [1:0]       C_LAST_PH   = 2'(TICKS_PER_BIT - 1);
    localparam logic [3:0]       C_MISS_LIM  = 4'(MISS_LIMIT);
    localparam logic [C_WP_W-1:0]   C_WP_LAST   = C_WP_W'(DELAY_BITS - 1);
    localparam logic [C_FILL_W-1:0] C_FILL_FULL = C_FILL_W'(DELAY_BITS);
    // Mask widened to the full 7-bit slot index range for safe indexing.
    localparam logic [127:0]     C_MASK_EXT  = 128'(SLOT_MASK);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers; third c4 stage is the edge detector.
    // ------------------------------------------------------------------
    logic r_c4_s1, r_c4_s2, r_c4_s3;
    logic r_f0_s1, r_f0_s2;
    logic r_din_s1, r_din_s2;

    always_ff @(posedge clk50) begin
        if (!reset_rg_n) begin
            r_c4_s1  <= 1'b0;
            r_c4_s2  <= 1'b0;
            r_c4_s3  <= 1'b0;
            r_f0_s1  <= 1'b0;
            r_f0_s2  <= 1'b0;
            r_din_s1 <= 1'b0;
            r_din_s2 <= 1'b0;
        end else begin
            r_c4_s1  <= tdm.c4;
            r_c4_s2  <= r_c4_s1;
            r_c4_s3  <= r_c4_s2;
            r_f0_s1  <= tdm.f0;
            r_f0_s2  <= r_f0_s1;
            r_din_s1 <= tdm.data_in;
            r_din_s2 <= r_din_s1;
        end
    end

    logic w_tick;
    logic w_f0_low;
    assign w_tick   = r_c4_s2 & ~r_c4_s3;
    assign w_f0_low = w_tick & ~r_f0_s2;

    // ------------------------------------------------------------------
    // Tick index t = {bit_cnt, phase}
    // ------------------------------------------------------------------
    logic [9:0] r_bit_cnt;
    logic [1:0] r_phase;
    logic       r_bit_strobe;
    logic       r_din_smp;
    logic       w_wrap;
    logic [9:0] w_nxt_bit;
    logic [1:0] w_nxt_ph;
    logic [9:0] w_upd_bit;
    logic [1:0] w_upd_ph;

    assign w_wrap = (r_bit_cnt == C_LAST_BIT) && (r_phase == C_LAST_PH);

    always_comb begin
        w_nxt_bit = r_bit_cnt;
        w_nxt_ph  = r_phase + 2'd1;
        if (w_wrap) begin
            w_nxt_bit = 10'd0;
            w_nxt_ph  = 2'd0;
        end else if (r_phase == C_LAST_PH) begin
            w_nxt_bit = r_bit_cnt + 10'd1;
            w_nxt_ph  = 2'd0;
        end
        // A sampled f0 realigns the frame and wins over the increment.
        w_upd_bit = w_f0_low ? 10'd0 : w_nxt_bit;
        w_upd_ph  = w_f0_low ? 2'd0  : w_nxt_ph;
    end

    always_ff @(posedge clk50) begin
        if (!reset_rg_n) begin
            r_bit_cnt    <= 10'd0;
            r_phase      <= 2'd0;
            r_bit_strobe <= 1'b0;
            r_din_smp    <= 1'b0;
        end else begin
            r_bit_strobe <= w_tick && (w_upd_ph == C_LAST_PH);
            if (w_tick) begin
                r_bit_cnt <= w_upd_bit;
                r_phase   <= w_upd_ph;
                r_din_smp <= r_din_s2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock state machine
    // ------------------------------------------------------------------
    state_t     r_state, w_state_nxt;
    logic [3:0] r_miss,  w_miss_nxt;
    logic       w_err_inc;

    always_ff @(posedge clk50) begin
        if (!reset_rg_n) begin
            r_state <= ST_HUNT;
            r_miss  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_miss  <= w_miss_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_miss_nxt  = r_miss;
        w_err_inc   = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_f0_low) begin
                    w_state_nxt = ST_LOCKED;
                    w_miss_nxt  = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (w_tick) begin
                    if (w_wrap) begin
                        if (!r_f0_s2) begin
                            w_miss_nxt = 4'd0;
                        end else begin
                            // Flywheel: counter wraps anyway, miss recorded.
                            w_miss_nxt = r_miss + 4'd1;
                            w_err_inc  = 1'b1;
                            if (r_miss + 4'd1 == C_MISS_LIM) begin
                                w_state_nxt = ST_HUNT;
                            end
                        end
                    end else if (!r_f0_s2) begin
                        // Early frame pulse: realigned by the counter logic.
                        w_err_inc  = 1'b1;
                        w_miss_nxt = 4'd0;
                    end
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

`ifdef TDM_FRAME_DELAY_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    always_ff @(posedge clk50) begin
        if (!reset_rg_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_err_inc && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end
    assign tdm.err_cnt = r_err_cnt;
`else
    logic w_unused_err_inc;
    assign w_unused_err_inc = w_err_inc;
    assign tdm.err_cnt      = 8'd0;
`endif

    // ------------------------------------------------------------------
    // Delay line: read-before-write at wptr on every bit strobe. The
    // storage has no reset; the fill counter masks stale contents.
    // ------------------------------------------------------------------
    logic [DELAY_BITS-1:0] r_mem;
    logic [C_WP_W-1:0]     r_wptr;
    logic [C_FILL_W-1:0]   r_fill;
    logic                  r_data_out;

    always_ff @(posedge clk50) begin
        if (r_bit_strobe) begin
            r_mem[r_wptr] <= r_din_smp;
        end
    end

    always_ff @(posedge clk50) begin
        if (!reset_rg_n) begin
            r_wptr     <= '0;
            r_fill     <= '0;
            r_data_out <= 1'b0;
        end else if (r_bit_strobe) begin
            r_data_out <= (r_fill == C_FILL_FULL) ? r_mem[r_wptr] : 1'b0;
            r_wptr     <= (r_wptr == C_WP_LAST) ? '0 : r_wptr + 1'b1;
            if (r_fill != C_FILL_FULL) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot markers, one cycle behind bit_cnt
    // ------------------------------------------------------------------
    logic       r_slot_pulse;
    logic [6:0] w_slot;
    assign w_slot = r_bit_cnt[9:3];

    always_ff @(posedge clk50) begin
        if (!reset_rg_n) begin
            r_slot_pulse <= 1'b0;
        end else begin
            r_slot_pulse <= (r_state == ST_LOCKED) && C_MASK_EXT[w_slot];
        end
    end

    assign tdm.data_out   = r_data_out;
    assign tdm.bit_strobe = r_bit_strobe;
    assign tdm.bit_cnt    = r_bit_cnt;
    assign tdm.slot_pulse = r_slot_pulse;
    assign tdm.frame_lock = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_tdm_frame_delay.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tdm_frame_delay
// Description : Directed testbench for tdm_frame_delay (default parameters).
//               Lock/flywheel/early-f0 behaviour is driven from a vector
//               table; delay line, reset and slot markers use hand-written
//               sequences. Honours TDM_FRAME_DELAY_ERR_CNT_EN for err_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_frame_delay;

    localparam int C_DELAY = 384;
    localparam int C_NBITS = 450;

    logic clk50;
    logic reset_rg_n;
    tdm_frame_delay_if tdm_bus ();

    tdm_frame_delay dut (
        .clk50      (clk50),
        .reset_rg_n (reset_rg_n),
        .tdm        (tdm_bus.slave)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    int n_vec  = 0;
    int n_miss = 0;
    int strobe_seen;

    typedef struct {
        int         n_ticks;
        logic       f0_last;
        logic [9:0] exp_bit;
        logic       exp_lock;
        logic [7:0] exp_err;
    } vec_t;

    vec_t       vecs [16];
    logic       prbs [C_NBITS];
    logic [31:0] mask;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_err(input logic [7:0] e);
`ifdef TDM_FRAME_DELAY_ERR_CNT_EN
        return e;
`else
        return (e == 8'd0) ? 8'd0 : 8'd0;
`endif
    endfunction

    // One c4 period (3 high, 5 low clk50 cycles); f0/data set in the low phase.
    task automatic c4_cycle(input logic f0v, input logic dv);
        strobe_seen = 0;
        tdm_bus.f0      = f0v;
        tdm_bus.data_in = dv;
        repeat (3) @(negedge clk50);
        tdm_bus.c4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk50);
            strobe_seen += int'(tdm_bus.bit_strobe);
        end
        tdm_bus.c4 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk50);
            strobe_seen += int'(tdm_bus.bit_strobe);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " data_out"},   32'(tdm_bus.data_out),   32'd0);
        chk({tag, " bit_strobe"}, 32'(tdm_bus.bit_strobe), 32'd0);
        chk({tag, " bit_cnt"},    32'(tdm_bus.bit_cnt),    32'd0);
        chk({tag, " slot_pulse"}, 32'(tdm_bus.slot_pulse), 32'd0);
        chk({tag, " frame_lock"}, 32'(tdm_bus.frame_lock), 32'd0);
        chk({tag, " err_cnt"},    32'(tdm_bus.err_cnt),    32'd0);
    endtask

    task automatic reset_during_c4;
        reset_rg_n = 1'b0;
        c4_cycle(1'b1, 1'b0);
        reset_rg_n = 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] lfsr;
        int         t;
        mask = 32'h0000_0015;

        //            ticks f0   bit   lock err
        vecs[0]  = '{1,   1'b1, 10'd0,   1'b0, 8'd0};
        vecs[1]  = '{10,  1'b1, 10'd5,   1'b0, 8'd0};
        vecs[2]  = '{1,   1'b0, 10'd0,   1'b1, 8'd0};   // first lock
        vecs[3]  = '{255, 1'b1, 10'd127, 1'b1, 8'd0};
        vecs[4]  = '{256, 1'b1, 10'd255, 1'b1, 8'd0};   // last bit of frame
        vecs[5]  = '{1,   1'b0, 10'd0,   1'b1, 8'd0};   // good frame wrap
        vecs[6]  = '{512, 1'b0, 10'd0,   1'b1, 8'd0};   // full good frame
        vecs[7]  = '{200, 1'b1, 10'd100, 1'b1, 8'd0};
        vecs[8]  = '{1,   1'b0, 10'd0,   1'b1, 8'd1};   // early f0 at bit 100
        vecs[9]  = '{512, 1'b1, 10'd0,   1'b1, 8'd2};   // miss 1
        vecs[10] = '{512, 1'b1, 10'd0,   1'b1, 8'd3};   // miss 2
        vecs[11] = '{511, 1'b1, 10'd255, 1'b1, 8'd3};
        vecs[12] = '{1,   1'b1, 10'd0,   1'b0, 8'd4};   // miss 3 -> HUNT
        vecs[13] = '{100, 1'b1, 10'd50,  1'b0, 8'd4};
        vecs[14] = '{1,   1'b0, 10'd0,   1'b1, 8'd4};   // relock
        vecs[15] = '{1,   1'b0, 10'd0,   1'b1, 8'd5};   // back-to-back f0

        lfsr = 7'h7F;
        for (int i = 0; i < C_NBITS; i++) begin
            prbs[i] = lfsr[6];
            lfsr    = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end

        // Power-on reset
        reset_rg_n      = 1'b0;
        tdm_bus.c4      = 1'b0;
        tdm_bus.f0      = 1'b1;
        tdm_bus.data_in = 1'b0;
        repeat (4) @(negedge clk50);
        check_reset_state("por");
        reset_rg_n = 1'b1;

        // Delay line with f0 absent (HUNT free-run, no realignment)
        for (int k = 0; k < C_NBITS; k++) begin
            c4_cycle(1'b1, prbs[k]);
            chk($sformatf("strobe bit%0d tick0", k), 32'(strobe_seen), 32'd1);
            chk($sformatf("data_out bit%0d", k), 32'(tdm_bus.data_out),
                (k >= C_DELAY) ? 32'(prbs[k - C_DELAY]) : 32'd0);
            c4_cycle(1'b1, prbs[k]);
            chk($sformatf("strobe bit%0d tick1", k), 32'(strobe_seen), 32'd0);
            chk($sformatf("slot_pulse unlocked bit%0d", k), 32'(tdm_bus.slot_pulse), 32'd0);
        end
        chk("err_cnt in hunt", 32'(tdm_bus.err_cnt), 32'd0);

        // Reset mid-stream; fill must restart despite stale buffer contents
        reset_during_c4();
        check_reset_state("mid reset");
        for (int k = 0; k < 20; k++) begin
            c4_cycle(1'b1, 1'b1);
            c4_cycle(1'b1, 1'b1);
            chk($sformatf("refill data_out bit%0d", k), 32'(tdm_bus.data_out), 32'd0);
        end
        chk("refill bit_cnt", 32'(tdm_bus.bit_cnt), 32'd20);

        // Lock / flywheel / early-f0 table
        reset_during_c4();
        for (int v = 0; v < 16; v++) begin
            for (int j = 0; j < vecs[v].n_ticks; j++) begin
                c4_cycle((j == vecs[v].n_ticks - 1) ? vecs[v].f0_last : 1'b1, 1'b0);
            end
            chk($sformatf("vec%0d bit_cnt", v),    32'(tdm_bus.bit_cnt),    32'(vecs[v].exp_bit));
            chk($sformatf("vec%0d frame_lock", v), 32'(tdm_bus.frame_lock), 32'(vecs[v].exp_lock));
            chk($sformatf("vec%0d err_cnt", v),    32'(tdm_bus.err_cnt),    32'(exp_err(vecs[v].exp_err)));
        end

        // Slot markers over one locked frame, starting at t=0
        for (int i = 1; i <= 512; i++) begin
            c4_cycle((i == 512) ? 1'b0 : 1'b1, 1'b0);
            t = i % 512;
            chk($sformatf("slot_pulse t%0d", t), 32'(tdm_bus.slot_pulse), 32'(mask[t >> 4]));
        end
        chk("slot frame lock", 32'(tdm_bus.frame_lock), 32'd1);
        chk("slot frame err",  32'(tdm_bus.err_cnt),    32'(exp_err(8'd5)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
